// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor: ALU opcode encodings and datapath widths.
package cpu_pkg;

  localparam int DATA_W = 8;
  localparam int PC_W   = 32;
  localparam int OFF_W  = 8;

  typedef enum logic [2:0] {
    ALU_FWD = 3'b000,
    ALU_ADD = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SRL = 3'b101,
    ALU_SRA = 3'b110,
    ALU_ROR = 3'b111
  } alu_op_e;

endpackage

// File: rtl/alu_flow_unit_alu_core.sv
// Combinational 8-bit ALU with ZERO flag. The shifter ops exist only when ALU_SHIFT_EN is defined.
import cpu_pkg::*;

module alu_core #(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] DATA1,
  input  logic [DATA_W-1:0] DATA2,
  input  logic [2:0]        ALUOP,
  output logic [DATA_W-1:0] RESULT,
  output logic              ZERO
);

`ifdef ALU_SHIFT_EN
  logic [2:0]          shamt;
  logic [2*DATA_W-1:0] rot;
  assign shamt = DATA2[2:0];
  // Rotating the doubled word leaves the wrapped bits in the low half.
  assign rot   = {DATA1, DATA1} >> shamt;
`endif

  always_comb begin
    RESULT = '0;
    case (ALUOP)
      ALU_FWD: RESULT = DATA2;
      ALU_ADD: RESULT = DATA1 + DATA2;
      ALU_AND: RESULT = DATA1 & DATA2;
      ALU_OR:  RESULT = DATA1 | DATA2;
`ifdef ALU_SHIFT_EN
      ALU_SLL: RESULT = DATA1 << shamt;
      ALU_SRL: RESULT = DATA1 >> shamt;
      ALU_SRA: RESULT = DATA_W'($signed(DATA1) >>> shamt);
      ALU_ROR: RESULT = rot[DATA_W-1:0];
`endif
      default: RESULT = '0;
    endcase
  end

  assign ZERO = ~|RESULT;

endmodule

// File: rtl/alu_flow_unit.sv
// Execute stage: ALU, jump/branch select, target adder and PC register (optional shifter: ALU_SHIFT_EN).
import cpu_pkg::*;

module alu_flow_unit #(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int PC_W   = cpu_pkg::PC_W,
  parameter int OFF_W  = cpu_pkg::OFF_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [DATA_W-1:0] DATA1,
  input  logic [DATA_W-1:0] DATA2,
  input  logic [2:0]        ALUOP,
  input  logic              JUMP,
  input  logic              BRANCH,
  input  logic [OFF_W-1:0]  OFFSET,
  input  logic              STALL,
  output logic [DATA_W-1:0] RESULT,
  output logic              ZERO,
  output logic              FLOW_SEL,
  output logic [PC_W-1:0]   PC,
  output logic [PC_W-1:0]   PC_PLUS4,
  output logic [PC_W-1:0]   TARGET
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] off_ext;

  alu_core #(.DATA_W(DATA_W)) u_alu (
    .DATA1  (DATA1),
    .DATA2  (DATA2),
    .ALUOP  (ALUOP),
    .RESULT (RESULT),
    .ZERO   (ZERO)
  );

  // OFFSET counts instructions, so it is scaled to bytes after sign extension.
  assign off_ext  = {{(PC_W-OFF_W){OFFSET[OFF_W-1]}}, OFFSET};
  assign PC_PLUS4 = pc_q + PC_W'(4);
  assign TARGET   = PC_PLUS4 + (off_ext << 2);
  assign FLOW_SEL = JUMP | (BRANCH & ZERO);

  always_comb begin
    pc_d = pc_q;
    if (!STALL) begin
      pc_d = FLOW_SEL ? TARGET : PC_PLUS4;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC = pc_q;

endmodule

// File: tb/tb_alu_flow_unit.sv
// Directed self-checking bench for alu_flow_unit (shift checks follow ALU_SHIFT_EN).
`timescale 1ns/1ps
module tb_alu_flow_unit;

  logic        CLK;
  logic        RESET;
  logic [7:0]  DATA1;
  logic [7:0]  DATA2;
  logic [2:0]  ALUOP;
  logic        JUMP;
  logic        BRANCH;
  logic [7:0]  OFFSET;
  logic        STALL;
  logic [7:0]  RESULT;
  logic        ZERO;
  logic        FLOW_SEL;
  logic [31:0] PC;
  logic [31:0] PC_PLUS4;
  logic [31:0] TARGET;

  int tests = 0;
  int fails = 0;

  alu_flow_unit dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .DATA1    (DATA1),
    .DATA2    (DATA2),
    .ALUOP    (ALUOP),
    .JUMP     (JUMP),
    .BRANCH   (BRANCH),
    .OFFSET   (OFFSET),
    .STALL    (STALL),
    .RESULT   (RESULT),
    .ZERO     (ZERO),
    .FLOW_SEL (FLOW_SEL),
    .PC       (PC),
    .PC_PLUS4 (PC_PLUS4),
    .TARGET   (TARGET)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic alu(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    ALUOP = op;
    DATA1 = a;
    DATA2 = b;
    #1;
  endtask

  // Advance one rising edge and settle outputs.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RESET = 1'b0; DATA1 = 8'h00; DATA2 = 8'h00; ALUOP = 3'b000;
    JUMP = 1'b0; BRANCH = 1'b0; OFFSET = 8'h00; STALL = 1'b0;
    #12;
    check("reset_pc", PC, 32'h0);
    check("reset_pc4", PC_PLUS4, 32'h4);

    // ALU vectors
    alu(3'b001, 8'h7F, 8'h01);
    check("add_res", {24'h0, RESULT}, 32'h80);
    check("add_zero", {31'h0, ZERO}, 32'h0);
    alu(3'b001, 8'h05, 8'hFB);
    check("add_wrap_res", {24'h0, RESULT}, 32'h00);
    check("add_wrap_zero", {31'h0, ZERO}, 32'h1);
    alu(3'b000, 8'hFF, 8'h00);
    check("fwd_res", {24'h0, RESULT}, 32'h00);
    check("fwd_zero", {31'h0, ZERO}, 32'h1);
    alu(3'b010, 8'hF0, 8'h3C);
    check("and_res", {24'h0, RESULT}, 32'h30);
    alu(3'b011, 8'hF0, 8'h0F);
    check("or_res", {24'h0, RESULT}, 32'hFF);
    check("or_zero", {31'h0, ZERO}, 32'h0);
`ifdef ALU_SHIFT_EN
    alu(3'b100, 8'h81, 8'h03);
    check("sll", {24'h0, RESULT}, 32'h08);
    alu(3'b101, 8'h81, 8'h03);
    check("srl", {24'h0, RESULT}, 32'h10);
    alu(3'b110, 8'h81, 8'h03);
    check("sra", {24'h0, RESULT}, 32'hF0);
    alu(3'b111, 8'h81, 8'h03);
    check("ror", {24'h0, RESULT}, 32'h30);
    alu(3'b111, 8'h81, 8'hF8);
    check("ror_sh0", {24'h0, RESULT}, 32'h81);
`else
    alu(3'b100, 8'h81, 8'h03);
    check("op100_res", {24'h0, RESULT}, 32'h00);
    check("op100_zero", {31'h0, ZERO}, 32'h1);
    alu(3'b111, 8'hFF, 8'h01);
    check("op111_res", {24'h0, RESULT}, 32'h00);
`endif

    // Release reset between edges; first edge loads PC+4 of PC=0, here via jump to 0x10.
    alu(3'b000, 8'h00, 8'h01);
    RESET = 1'b1;
    JUMP = 1'b1; OFFSET = 8'h03;
    #1;
    check("jmp0_target", TARGET, 32'h10);
    tick();
    check("pc_0x10", PC, 32'h10);

    // Taken branch backwards: ZERO from FORWARD of 0.
    JUMP = 1'b0; BRANCH = 1'b1; OFFSET = 8'hFE;
    alu(3'b000, 8'hFF, 8'h00);
    check("beq_target", TARGET, 32'h0C);
    check("beq_flow", {31'h0, FLOW_SEL}, 32'h1);
    tick();
    check("beq_taken_pc", PC, 32'h0C);

    // Back to 0x10, then not-taken branch.
    BRANCH = 1'b0;
    tick();
    check("seq_pc", PC, 32'h10);
    BRANCH = 1'b1;
    alu(3'b000, 8'h00, 8'h01);
    check("bne_flow", {31'h0, FLOW_SEL}, 32'h0);
    tick();
    check("bne_pc", PC, 32'h14);

    // Jump and branch together still taken: 0x18 + 2*4 = 0x20.
    JUMP = 1'b1; OFFSET = 8'h02;
    tick();
    check("jmp_br_pc", PC, 32'h20);
    BRANCH = 1'b0; OFFSET = 8'h03;
    tick();
    check("jmp_pc_0x30", PC, 32'h30);

    // Jump to 0xFFFFFFFC (0x34 - 14*4), then fall through and wrap.
    OFFSET = 8'hF2;
    #1;
    check("neg_target", TARGET, 32'hFFFFFFFC);
    tick();
    check("pc_top", PC, 32'hFFFFFFFC);
    JUMP = 1'b0;
    #1;
    check("pc4_wrap", PC_PLUS4, 32'h0);
    tick();
    check("pc_wrap", PC, 32'h0);

    // Stall at 0x08.
    tick();
    tick();
    check("pc_0x08", PC, 32'h08);
    STALL = 1'b1;
    tick();
    tick();
    tick();
    check("stall_hold", PC, 32'h08);
    STALL = 1'b0;
    tick();
    check("stall_release", PC, 32'h0C);

    // Jump to 0x40 (0x10 + 12*4), then asynchronous reset while stalled.
    JUMP = 1'b1; OFFSET = 8'h0C;
    tick();
    check("pc_0x40", PC, 32'h40);
    JUMP = 1'b0; STALL = 1'b1;
    tick();
    check("stall_0x40", PC, 32'h40);
    #2;
    RESET = 1'b0;
    #1;
    check("async_reset_pc", PC, 32'h0);
    check("async_reset_pc4", PC_PLUS4, 32'h4);
    STALL = 1'b0;
    #1;
    RESET = 1'b1;
    tick();
    check("post_reset_pc", PC, 32'h4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
